// File: rtl/lsu_mem_ctrl_if.sv
// rtl/lsu_mem_ctrl_if.sv - pipeline request/response and data-memory signals of the load/store unit
interface lsu_mem_ctrl_if #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  MemRead;
    logic                  MemWrite;
    logic [2:0]            Funct3;
    logic [DM_ADDRESS-1:0] addr;
    logic [DATA_W-1:0]     wdata;
    logic                  resp_valid;
    logic [DATA_W-1:0]     rdata;
    logic                  fault;
    logic [DM_ADDRESS-1:0] mem_addr;
    logic                  mem_re;
    logic                  mem_we;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W-1:0]     mem_rdata;

    modport slave (
        input  req_valid, MemRead, MemWrite, Funct3, addr, wdata, mem_rdata,
        output req_ready, resp_valid, rdata, fault, mem_addr, mem_re, mem_we, mem_wdata
    );

    modport master (
        output req_valid, MemRead, MemWrite, Funct3, addr, wdata, mem_rdata,
        input  req_ready, resp_valid, rdata, fault, mem_addr, mem_re, mem_we, mem_wdata
    );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - MEM-stage load/store controller; sub-word stores via read-modify-write
module lsu_mem_ctrl #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) (
    input logic           clk,
    input logic           reset,
    lsu_mem_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_DATA, WR, RESP} state_t;

    state_t      state;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic [15:0] wdata_q;
    logic        load_q;

    logic              req_load;
    logic              req_store;
    logic              req_fault;
    logic              accept;
    logic [4:0]        lane_shift;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] load_ext;
    logic [DATA_W-1:0] merged;

    assign req_load  = bus.MemRead && !bus.MemWrite;
    assign req_store = bus.MemWrite && !bus.MemRead;
    assign accept    = (state == IDLE) && bus.req_valid && (bus.MemRead || bus.MemWrite);

    // Fault covers illegal encodings, unsigned stores, conflicting ops and misalignment
    assign req_fault = (bus.MemRead && bus.MemWrite)
                    || (bus.Funct3 == 3'b011)
                    || (bus.Funct3[2:1] == 2'b11)
                    || (req_store && bus.Funct3[2])
                    || ((bus.Funct3[1:0] == 2'b01) && bus.addr[0])
                    || ((bus.Funct3[1:0] == 2'b10) && (bus.addr[1:0] != 2'b00));

    assign lane_shift = {off_q, 3'b000};
    assign shifted    = bus.mem_rdata >> lane_shift;

    always_comb begin
        load_ext = shifted;
        case (f3_q)
            3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_ext = {24'd0, shifted[7:0]};
            3'b101:  load_ext = {16'd0, shifted[15:0]};
            default: load_ext = shifted;
        endcase
    end

    always_comb begin
        merged = bus.mem_rdata;
        if (f3_q[1:0] == 2'b00)
            merged[lane_shift +: 8] = wdata_q[7:0];
        else
            merged[{off_q[1], 4'b0000} +: 16] = wdata_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            f3_q           <= 3'b000;
            off_q          <= 2'b00;
            wdata_q        <= 16'd0;
            load_q         <= 1'b0;
            bus.req_ready  <= 1'b1;
            bus.resp_valid <= 1'b0;
            bus.fault      <= 1'b0;
            bus.rdata      <= '0;
            bus.mem_re     <= 1'b0;
            bus.mem_we     <= 1'b0;
            bus.mem_addr   <= '0;
            bus.mem_wdata  <= '0;
        end else begin
            bus.resp_valid <= 1'b0;
            bus.mem_re     <= 1'b0;
            bus.mem_we     <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        f3_q          <= bus.Funct3;
                        off_q         <= bus.addr[1:0];
                        wdata_q       <= bus.wdata[15:0];
                        load_q        <= req_load;
                        bus.req_ready <= 1'b0;
                        if (req_fault) begin
                            bus.resp_valid <= 1'b1;
                            bus.fault      <= 1'b1;
                            bus.rdata      <= '0;
                            state          <= RESP;
                        end else begin
                            bus.mem_addr <= {bus.addr[DM_ADDRESS-1:2], 2'b00};
                            if (req_store && (bus.Funct3[1:0] == 2'b10)) begin
                                bus.mem_wdata <= bus.wdata;
                                bus.mem_we    <= 1'b1;
                                state         <= WR;
                            end else begin
                                bus.mem_re <= 1'b1;
                                state      <= RD_ISSUE;
                            end
                        end
                    end
                end
                RD_ISSUE: state <= RD_DATA;
                RD_DATA: begin
                    if (load_q) begin
                        bus.rdata      <= load_ext;
                        bus.fault      <= 1'b0;
                        bus.resp_valid <= 1'b1;
                        state          <= RESP;
                    end else begin
                        bus.mem_wdata <= merged;
                        bus.mem_we    <= 1'b1;
                        state         <= WR;
                    end
                end
                WR: begin
                    bus.rdata      <= '0;
                    bus.fault      <= 1'b0;
                    bus.resp_valid <= 1'b1;
                    state          <= RESP;
                end
                RESP: begin
                    bus.fault     <= 1'b0;
                    bus.req_ready <= 1'b1;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store initiator in the MEM stage; sits between the pipeline and the word-wide data memory.
- Converts RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW requests into word-aligned memory transactions.
- Sub-word stores use read-modify-write; loads are extracted by byte lane and sign/zero-extended.
- Holds the pipeline with req_ready until each access completes.

Parameters:
DM_ADDRESS, 9, byte-address width presented to data memory
DATA_W, 32, data width (fixed at 32; other values unsupported)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous active-low reset
req_valid  in  1  MEM-stage request present
req_ready  out  1  high only in IDLE; request accepted on a clk edge with req_valid&&req_ready
MemRead  in  1  load request (from control unit)
MemWrite  in  1  store request (from control unit)
Funct3  in  3  instruction bits 14:12
addr  in  DM_ADDRESS  byte address (ALU result LSBs)
wdata  in  DATA_W  store data (rs2)
resp_valid  out  1  one-cycle completion pulse
rdata  out  DATA_W  extended load result, valid with resp_valid
fault  out  1  misaligned or illegal access, valid with resp_valid
mem_addr  out  DM_ADDRESS  word-aligned address ({addr[DM_ADDRESS-1:2],2'b00})
mem_re  out  1  read strobe
mem_we  out  1  full-word write strobe
mem_wdata  out  DATA_W  word written
mem_rdata  in  DATA_W  memory read data, valid the cycle after the edge that samples mem_re

Behaviour:
- All outputs are registered.
- Reset (asynchronous, reset=0):
  - state=IDLE, req_ready=1, resp_valid=0, fault=0.
  - rdata=0, mem_re=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Acceptance latches Funct3, addr, wdata and op.
  - Requests with neither MemRead nor MemWrite are ignored, not accepted.
- Byte lanes are little-endian: lane k = bits[8k+7:8k], offset = addr[1:0].
- Legal accesses:
  - byte: any offset.
  - half: offset 0 or 2.
  - word: offset 0.
  - LBU/LHU exist for loads only.
- Fault conditions, decided at acceptance:
  - misaligned access.
  - Funct3 011, 110 or 111.
  - store with Funct3 100 or 101.
  - MemRead and MemWrite both high.
- On fault: go directly to RESP with fault=1, rdata=0; no mem_re and no mem_we are issued.
- States:
  - IDLE: req_ready=1. On accept, branch:
    - fault -> RESP
    - load, SB, SH -> RD_ISSUE
    - SW -> WR
  - RD_ISSUE: mem_re=1 for one cycle -> RD_DATA.
  - RD_DATA: mem_rdata is valid.
    - Load: extract and extend into rdata -> RESP.
    - SB/SH: merge wdata low byte/half into the addressed lane of mem_rdata, place result on mem_wdata -> WR.
  - WR: mem_we=1 for one cycle.
    - mem_wdata = wdata for SW, merged word otherwise -> RESP.
  - RESP: resp_valid=1 for one cycle, fault as decided, req_ready=0 -> IDLE.
- Load extension:
  - LB/LH sign-extend from the selected lane's MSB.
  - LBU/LHU zero-extend.
- Latency:
  - loads and SB/SH: resp_valid in the 3rd cycle after accept (SB/SH in the 4th).
  - SW: 2nd cycle after accept.
  - faults: 1st cycle after accept.
- Back-to-back operation:
  - a new request can be accepted the cycle after RESP.
  - no overlap; req_ready=0 in every non-IDLE state.
- rdata holds its value until the next load completes. For stores, rdata=0 with resp_valid.
- mem_addr is held constant from acceptance through WR.
- Reset mid-operation:
  - Returns to IDLE immediately; mem_we deasserts asynchronously.
  - An aborted RMW leaves the memory word unmodified unless the WR edge has already occurred.
  - No resp_valid is issued for the aborted request.
- Request inputs are sampled only at acceptance; later changes have no effect until IDLE.

Test Plan:
- Memory word 0x10 = 0x8899AABB.
  - LB at addr 0x12 -> rdata=0xFFFFFF99, fault=0, resp_valid 3 cycles after accept.
  - LBU at addr 0x12 -> rdata=0x00000099.
- Memory word 0x10 = 0x8899AABB.
  - SB wdata=0x12345677 at addr 0x11 -> exactly one mem_we with mem_wdata=0x889977BB.
  - A following LW at 0x10 returns 0x889977BB.
- SH wdata=0x0000CAFE at addr 0x22 over 0x11223344 -> mem_wdata=0xCAFE3344.
- LH at addr 0x23 -> fault=1, rdata=0, no mem_re or mem_we pulse, resp_valid 1 cycle after accept.
- SW at 0x04 then LW at 0x04 back-to-back with req_valid held high:
  - SW completes in 2 cycles; the LW is accepted the cycle after RESP and returns the written value.
  - req_ready=0 throughout both operations.
- SB in flight: assert reset=0 during RD_DATA.
  - Outputs reach reset values immediately, no mem_we, memory unchanged.
  - After release, req_ready=1 and the next request proceeds normally.
